hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

HI/LO controller for the execute stage. It issues MULT/MULTU/DIV/DIVU to the fixed-latency pipelined multiply/divide unit `dmu`, holds that unit's operands and op code stable, and stalls EX until the result is valid. It then commits the result to the architectural HI/LO registers. It also services MTHI/MTLO writes and MFHI/MFLO reads, and cancels an in-flight operation on an EX flush.

## Interface
- WIDTH, 32, data width
- LAT, 5, number of clock edges from when `dmu_m` changes until `dmu_hi`/`dmu_lo` hold the matching result
- clk  in  1  clock; all state changes on the rising edge
- resetn  in  1  reset, asynchronous, active-low (clock `clk`, reset `resetn`: one clock; reset is asynchronous and active-low)
- op_valid  in  1  EX holds a HI/LO-class instruction this cycle
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
- rs_val  in  WIDTH  rs operand (dividend, multiplicand, or MT source)
- rt_val  in  WIDTH  rt operand (divisor, multiplier)
- ex_flush  in  1  cancel the EX instruction and any in-flight operation
- stall  out  1  hold EX/IF/ID this cycle
- dmu_a  out  WIDTH  registered operand a to `dmu`
- dmu_b  out  WIDTH  registered operand b to `dmu`
- dmu_m  out  4  registered op code to `dmu`: 0101 MULT, 0110 MULTU, 1011 DIV, 0111 DIVU, 0000 idle
- dmu_hi  in  WIDTH  `dmu` HI result (remainder for divides; `dmu` already orders the halves)
- dmu_lo  in  WIDTH  `dmu` LO result (quotient for divides)
- mf_data  out  WIDTH  HI or LO value for MFHI/MFLO
- mf_valid  out  1  mf_data is meaningful this cycle
- hi_q  out  WIDTH  architectural HI
- lo_q  out  WIDTH  architectural LO

## Operation
- State machine: IDLE and BUSY. A 3-bit counter `cnt` is used only in BUSY.
- Arithmetic op = op_valid & op[2]==0.
- IDLE, arithmetic op, no flush:
  - Next edge: dmu_a <= rs_val, dmu_b <= rt_val, dmu_m <= code for op, cnt <= 0, state <= BUSY.
- BUSY:
  - cnt increments each edge.
  - dmu_a, dmu_b and dmu_m are held constant. The divider IP samples continuously, so these must not change.
  - op_valid and op are ignored, including repeats of the same EX instruction while stalled.
- BUSY, cnt==LAT, no flush:
  - Next edge: hi_q <= dmu_hi, lo_q <= dmu_lo, dmu_m <= 0000, state <= IDLE.
  - Divide by zero commits whatever `dmu` returns; no trap.
- IDLE, MTHI: next edge hi_q <= rs_val, no stall. MTLO writes lo_q in the same way.
- MFHI/MFLO:
  - mf_data = hi_q or lo_q, combinational.
  - mf_valid = op_valid & op[2:1]==11 & state==IDLE & !ex_flush.
  - An MF in the cycle directly after an MT or a commit sees the new value, because the register has already been written.
- ex_flush has priority over everything:
  - In IDLE: no issue, no MT write.
  - In BUSY: next edge state <= IDLE, dmu_m <= 0000, HI/LO unchanged.
- stall = !ex_flush & ((IDLE & arithmetic op) | (BUSY & cnt!=LAT)).
- dmu_a/dmu_b keep their last values when idle.

## Timing
- Reset (asynchronous, resetn=0): state IDLE, cnt 0, hi_q/lo_q/dmu_a/dmu_b 0, dmu_m 0000. Combinationally, stall 0 and mf_valid 0.
- Reset mid-BUSY aborts the operation with no commit; `dmu` results that arrive afterwards are ignored.
- Issue sequence (arithmetic op presented in cycle T, state IDLE):
  - Cycle T: stall=1.
  - Edge T+1: BUSY, `dmu` sees operands.
  - Edges T+2..T+6: cnt goes 1..5.
  - Cycle T+6: cnt==LAT, stall=0.
  - Edge T+7: HI/LO committed, IDLE, EX advances.
- Stall is high for exactly LAT+1 cycles (T..T+5) per arithmetic op. Exactly one issue per instruction.
- The next instruction is presented at cycle T+7. It may be another arithmetic op (issues immediately, zero bubble) or MFHI/MFLO (reads the new value).
- MT/MF: zero stall, single cycle.
- Flush in BUSY at any cnt, including cnt==LAT: no commit. stall=0 in the flush cycle. IDLE next cycle.

## Test plan
Bench uses a behavioural `dmu` model with LAT=5 and the same op codes.
- MULT rs=0xFFFFFFFE, rt=3, op_valid held through stall -> stall high 6 cycles, one issue, hi_q=0xFFFFFFFF, lo_q=0xFFFFFFFA; MFLO next cycle -> mf_data=0xFFFFFFFA, mf_valid=1.
- DIVU rs=100, rt=7 -> dmu_a=100, dmu_b=7, dmu_m=0111 stable all BUSY cycles; commit lo_q=14, hi_q=2; dmu_m returns to 0000.
- MTHI rs=0x1234 then MFHI next cycle -> no stall, mf_data=0x1234.
- MULTU 5*5 with prior HI/LO=0xA/0xB, ex_flush at cnt=3 -> stall 0 that cycle, IDLE next, hi_q=0xA, lo_q=0xB unchanged; a following DIV issues normally.
- resetn low at cnt=2 of a MULT -> hi_q/lo_q=0, stall=0, dmu_m=0000 immediately; no commit after release.
- MULT 2*3 immediately followed by MULTU 4*4 in cycle T+7 -> second issues at edge T+8 with no bubble; final lo_q=16, hi_q=0.

Source files
------------

// File: rtl/hilo_ctrl.sv
// HI/LO controller: issues multiply/divide ops to the fixed-latency dmu, stalls EX until
// the result is ready, commits HI/LO, and services MTHI/MTLO/MFHI/MFLO and EX flushes.
module hilo_ctrl #(
    parameter int WIDTH = 32,
    parameter int LAT   = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             ex_flush,
    output logic             stall,
    output logic [WIDTH-1:0] dmu_a,
    output logic [WIDTH-1:0] dmu_b,
    output logic [3:0]       dmu_m,
    input  logic [WIDTH-1:0] dmu_hi,
    input  logic [WIDTH-1:0] dmu_lo,
    output logic [WIDTH-1:0] mf_data,
    output logic             mf_valid,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam logic [2:0] LAT_CNT = 3'(LAT);

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic       w_arith;
    logic       w_idle;
    logic       w_done;
    logic       w_issue;
    logic       w_commit;
    logic       w_mthi;
    logic       w_mtlo;
    logic [3:0] w_code;

    assign w_idle  = (r_state == S_IDLE);
    assign w_arith = op_valid & ~op[2];
    assign w_done  = (r_state == S_BUSY) & (r_cnt == LAT_CNT);

    // dmu op encoding for the four arithmetic instructions
    always_comb begin
        w_code = 4'b0000;
        case (op[1:0])
            2'b00: w_code = 4'b0101;
            2'b01: w_code = 4'b0110;
            2'b10: w_code = 4'b1011;
            2'b11: w_code = 4'b0111;
            default: w_code = 4'b0000;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_arith && !ex_flush) w_state_next = S_BUSY;
            S_BUSY: if (ex_flush || w_done)   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_issue  = w_idle & w_arith & ~ex_flush;
        w_commit = w_done & ~ex_flush;
        w_mthi   = w_idle & op_valid & (op == 3'b100) & ~ex_flush;
        w_mtlo   = w_idle & op_valid & (op == 3'b101) & ~ex_flush;
        stall    = ~ex_flush & ((w_idle & w_arith) | ((r_state == S_BUSY) & (r_cnt != LAT_CNT)));
        mf_valid = op_valid & (op[2:1] == 2'b11) & w_idle & ~ex_flush;
        mf_data  = op[0] ? r_lo : r_hi;
    end

    // Operands are only loaded on issue so the continuously sampling dmu sees stable inputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= 3'd0;
            r_a   <= '0;
            r_b   <= '0;
            r_m   <= 4'b0000;
        end else if (w_issue) begin
            r_cnt <= 3'd0;
            r_a   <= rs_val;
            r_b   <= rt_val;
            r_m   <= w_code;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 3'd1;
            if (ex_flush || w_done) r_m <= 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= dmu_hi;
            r_lo <= dmu_lo;
        end else begin
            if (w_mthi) r_hi <= rs_val;
            if (w_mtlo) r_lo <= rs_val;
        end
    end

    assign dmu_a = r_a;
    assign dmu_b = r_b;
    assign dmu_m = r_m;
    assign hi_q  = r_hi;
    assign lo_q  = r_lo;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a behavioural fixed-latency multiply/divide unit.
module tb_hilo_ctrl;

    localparam int WIDTH = 32;
    localparam int LAT   = 5;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    logic             clk = 1'b0;
    logic             resetn;
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             ex_flush;
    logic             stall;
    logic [WIDTH-1:0] dmu_a;
    logic [WIDTH-1:0] dmu_b;
    logic [3:0]       dmu_m;
    logic [WIDTH-1:0] dmu_hi;
    logic [WIDTH-1:0] dmu_lo;
    logic [WIDTH-1:0] mf_data;
    logic             mf_valid;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    int total = 0;
    int bad   = 0;

    hilo_ctrl #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .ex_flush(ex_flush), .stall(stall),
        .dmu_a(dmu_a), .dmu_b(dmu_b), .dmu_m(dmu_m),
        .dmu_hi(dmu_hi), .dmu_lo(dmu_lo),
        .mf_data(mf_data), .mf_valid(mf_valid), .hi_q(hi_q), .lo_q(lo_q)
    );

    always #5 clk = ~clk;

    // Behavioural dmu: result of the inputs seen after an edge appears LAT edges later
    function automatic logic [63:0] dmu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (m)
            4'b0101: return sa * sb;
            4'b0110: return {32'd0, a} * {32'd0, b};
            4'b1011: begin
                if (b == 0) return 64'd0;
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            4'b0111: begin
                if (b == 0) return 64'd0;
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= dmu_f(dmu_a, dmu_b, dmu_m);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dmu_hi = pipe[LAT-1][63:32];
    assign dmu_lo = pipe[LAT-1][31:0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present an arithmetic op at the current negedge and hold it until stall drops.
    // Counts stall cycles, issues, and operand changes while busy.
    task automatic run_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] code, output int nst, output int nis, output int nhold);
        logic [3:0] prev;
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        nst = 0; nis = 0; nhold = 0;
        prev = dmu_m;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (dmu_m != prev && dmu_m != 4'b0000) nis++;
            prev = dmu_m;
            if (i > 0 && (dmu_a != a || dmu_b != b || dmu_m != code)) nhold++;
            if (!stall) break;
            nst++;
            @(negedge clk);
        end
    endtask

    task automatic do_arith(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] code);
        int nst, nis, nhold;
        run_arith(o, a, b, code, nst, nis, nhold);
        $display("txn %s op=%0d a=%0h b=%0h stall_cycles=%0d issues=%0d", tag, o, a, b, nst, nis);
        chk({tag, "_stall_cycles"}, 64'(nst), 64'(LAT + 1));
        chk({tag, "_issues"}, 64'(nis), 64'd1);
        chk({tag, "_operands_held"}, 64'(nhold), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; op_valid = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0; ex_flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", hi_q, 0);
        chk("rst_lo", lo_q, 0);
        chk("rst_dmu_a", dmu_a, 0);
        chk("rst_dmu_b", dmu_b, 0);
        chk("rst_dmu_m", dmu_m, 0);
        chk("rst_stall", stall, 0);
        chk("rst_mf_valid", mf_valid, 0);
        @(negedge clk);
        resetn = 1'b1;

        // MULT -2 * 3, then MFLO
        @(negedge clk);
        do_arith("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 4'b0101);
        @(negedge clk);
        chk("mult_hi", hi_q, 32'hFFFF_FFFF);
        chk("mult_lo", lo_q, 32'hFFFF_FFFA);
        op_valid = 1'b1; op = OP_MFLO;
        #1;
        $display("txn mflo data=%0h valid=%0d", mf_data, mf_valid);
        chk("mflo_data", mf_data, 32'hFFFF_FFFA);
        chk("mflo_valid", mf_valid, 1);
        chk("mflo_stall", stall, 0);

        // DIVU 100 / 7
        @(negedge clk);
        do_arith("divu", OP_DIVU, 32'd100, 32'd7, 4'b0111);
        @(negedge clk);
        op_valid = 1'b0;
        chk("divu_lo", lo_q, 32'd14);
        chk("divu_hi", hi_q, 32'd2);
        chk("divu_m_idle", dmu_m, 4'b0000);
        chk("divu_a_kept", dmu_a, 32'd100);

        // MTHI then MFHI
        @(negedge clk);
        op_valid = 1'b1; op = OP_MTHI; rs_val = 32'h1234;
        #1;
        chk("mthi_stall", stall, 0);
        @(negedge clk);
        op = OP_MFHI;
        #1;
        $display("txn mthi/mfhi data=%0h valid=%0d", mf_data, mf_valid);
        chk("mfhi_data", mf_data, 32'h1234);
        chk("mfhi_valid", mf_valid, 1);
        chk("mfhi_lo_kept", lo_q, 32'd14);

        // Preload HI/LO, then MULTU 5*5 flushed at cnt=3
        @(negedge clk);
        op = OP_MTHI; rs_val = 32'hA;
        @(negedge clk);
        op = OP_MTLO; rs_val = 32'hB;
        @(negedge clk);
        op = OP_MULTU; rs_val = 32'd5; rt_val = 32'd5;
        repeat (4) @(negedge clk);
        ex_flush = 1'b1;
        #1;
        $display("txn multu flushed at cnt=3");
        chk("flush3_stall", stall, 0);
        @(negedge clk);
        ex_flush = 1'b0; op = OP_MFHI;
        #1;
        chk("flush3_idle_mf_valid", mf_valid, 1);
        chk("flush3_mf_data", mf_data, 32'hA);
        chk("flush3_dmu_m", dmu_m, 4'b0000);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        chk("flush3_hi", hi_q, 32'hA);
        chk("flush3_lo", lo_q, 32'hB);

        // DIV -7 / 2 issues normally after the flush
        do_arith("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'b1011);
        @(negedge clk);
        op_valid = 1'b0;
        chk("div_lo", lo_q, 32'hFFFF_FFFD);
        chk("div_hi", hi_q, 32'hFFFF_FFFF);

        // MULT 3*3 flushed at cnt==LAT: no commit
        @(negedge clk);
        op_valid = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3;
        repeat (LAT + 1) @(negedge clk);
        ex_flush = 1'b1;
        #1;
        $display("txn mult flushed at cnt=LAT");
        chk("flushlat_stall", stall, 0);
        @(negedge clk);
        ex_flush = 1'b0; op = OP_MFLO;
        #1;
        chk("flushlat_mf_valid", mf_valid, 1);
        chk("flushlat_lo", mf_data, 32'hFFFF_FFFD);
        @(negedge clk);
        op_valid = 1'b0;
        chk("flushlat_hi", hi_q, 32'hFFFF_FFFF);

        // MF suppressed by a flush
        op_valid = 1'b1; op = OP_MFHI; ex_flush = 1'b1;
        #1;
        chk("mf_flush_valid", mf_valid, 0);
        @(negedge clk);
        op_valid = 1'b0; ex_flush = 1'b0;

        // Reset at cnt=2 of MULT 7*7
        @(negedge clk);
        op_valid = 1'b1; op = OP_MULT; rs_val = 32'd7; rt_val = 32'd7;
        repeat (3) @(negedge clk);
        resetn = 1'b0; op_valid = 1'b0;
        #1;
        $display("txn mult aborted by reset at cnt=2");
        chk("rstbusy_hi", hi_q, 0);
        chk("rstbusy_lo", lo_q, 0);
        chk("rstbusy_stall", stall, 0);
        chk("rstbusy_dmu_m", dmu_m, 4'b0000);
        @(negedge clk);
        resetn = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("rstbusy_after_hi", hi_q, 0);
        chk("rstbusy_after_lo", lo_q, 0);

        // MULT 2*3 then MULTU 4*4 back to back
        do_arith("mult_b2b", OP_MULT, 32'd2, 32'd3, 4'b0101);
        @(negedge clk);
        chk("b2b_first_lo", lo_q, 32'd6);
        chk("b2b_first_hi", hi_q, 32'd0);
        do_arith("multu_b2b", OP_MULTU, 32'd4, 32'd4, 4'b0110);
        @(negedge clk);
        op_valid = 1'b0;
        chk("b2b_lo", lo_q, 32'd16);
        chk("b2b_hi", hi_q, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
